// File: rtl/alu_issue_stage.sv
// Issue/capture stage for the 16-bit combinational ALU: operation FIFO, issue of the
// head entry with illegal-opcode screening, and a registered tagged result with valid/ready.
module alu_issue_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [2:0]       mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_ill;

  assign empty    = (count == '0);
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid || out_ready);
  assign head_ill = !empty && (mem_op[rd_ptr] == 3'b111);

  // Illegal opcodes are issued as ADD; their result is discarded at capture.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 3'b000;
    if (!empty) begin
      alu_a  = mem_a[rd_ptr];
      alu_b  = mem_b[rd_ptr];
      alu_op = head_ill ? 3'b000 : mem_op[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_op[wr_ptr]  <= in_op;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_result <= head_ill ? '0 : alu_result;
      out_tag    <= mem_tag[rd_ptr];
      out_err    <= head_ill;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a randomized run
// scored against a queue-based transaction model.
module tb_alu_issue_stage;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic [2:0]       count;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } txn_t;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_err(out_err),
    .count(count)
  );

  // The external combinational ALU the stage feeds.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a * alu_b;
      3'b010: alu_result = alu_a - alu_b;
      3'b011: alu_result = alu_a & alu_b;
      3'b100: alu_result = alu_a | alu_b;
      3'b101: alu_result = alu_a ^ alu_b;
      3'b110: alu_result = ~alu_a;
      default: alu_result = 16'hDEAD;
    endcase
  end

  // Expected result of one operation, from plain integer arithmetic modulo 2^16.
  function automatic txn_t expect_op(input int unsigned a, input int unsigned b,
                                     input int unsigned op, input logic [TAG_W-1:0] tag);
    int unsigned r;
    txn_t t;
    case (op)
      0: r = a + b;
      1: r = a * b;
      2: r = a + 65536 - b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = 65535 - a;
      default: r = 0;
    endcase
    t.res = WIDTH'(r % 65536);
    t.tag = tag;
    t.err = (op == 7);
    return t;
  endfunction

  task automatic set_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_chk++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_chk++; if (alu_op !== 3'b000) $display("FAIL reset_alu_op got %b want 000", alu_op); else n_pass++;
    n_chk++; if (alu_a !== 16'h0 || alu_b !== 16'h0) $display("FAIL reset_alu_ab got %h/%h want 0/0", alu_a, alu_b); else n_pass++;
    n_chk++; if (out_result !== 16'h0 || out_tag !== 4'h0 || out_err !== 1'b0)
      $display("FAIL reset_out_regs got %h/%h/%b want 0/0/0", out_result, out_tag, out_err); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    set_op(16'h0005, 16'h0003, 3'b000, 4'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (count !== 3'd1) $display("FAIL add_count got %0d want 1", count); else n_pass++;
    n_chk++; if (alu_a !== 16'h0005 || alu_b !== 16'h0003) $display("FAIL add_issue got %h/%h want 0005/0003", alu_a, alu_b); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL add_early_valid got %b want 0", out_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", out_valid); else n_pass++;
    n_chk++; if (out_result !== 16'h0008) $display("FAIL add_result got %h want 0008", out_result); else n_pass++;
    n_chk++; if (out_tag !== 4'd1 || out_err !== 1'b0) $display("FAIL add_tag_err got %h/%b want 1/0", out_tag, out_err); else n_pass++;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL add_drain got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_result !== 16'h0008) $display("FAIL add_hold got %h want 0008", out_result); else n_pass++;
  endtask

  task automatic test_wrap;
    logic [WIDTH-1:0] va [3] = '{16'h0100, 16'h0000, 16'h00FF};
    logic [WIDTH-1:0] vb [3] = '{16'h0100, 16'h0001, 16'h1234};
    logic [2:0]       vo [3] = '{3'b001, 3'b010, 3'b110};
    logic [WIDTH-1:0] ve [3] = '{16'h0000, 16'hFFFF, 16'hFF00};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(va[i], vb[i], vo[i], TAG_W'(i + 4));
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b1 || out_result !== ve[i])
        $display("FAIL wrap_%0d got valid=%b result=%h want 1/%h", i, out_valid, out_result, ve[i]); else n_pass++;
      n_chk++; if (out_tag !== TAG_W'(i + 4)) $display("FAIL wrap_tag_%0d got %h want %h", i, out_tag, TAG_W'(i + 4)); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    set_op(16'h0001, 16'h0001, 3'b111, 4'd7);
    @(negedge clk);
    n_chk++; if (alu_op !== 3'b000) $display("FAIL ill_alu_op got %b want 000", alu_op); else n_pass++;
    set_op(16'h0002, 16'h0002, 3'b000, 4'd3);
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_err !== 1'b1) $display("FAIL ill_err got valid=%b err=%b want 1/1", out_valid, out_err); else n_pass++;
    n_chk++; if (out_result !== 16'h0 || out_tag !== 4'd7) $display("FAIL ill_result got %h/%h want 0000/7", out_result, out_tag); else n_pass++;
    @(negedge clk);
    n_chk++; if (out_err !== 1'b0 || out_result !== 16'h0004 || out_tag !== 4'd3)
      $display("FAIL ill_next got err=%b result=%h tag=%h want 0/0004/3", out_err, out_result, out_tag); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_op(WIDTH'(i + 10), 16'h0, 3'b000, TAG_W'(i));
      n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_ready_%0d got %b want 1", i, in_ready); else n_pass++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++; if (count !== 3'd4) $display("FAIL bp_count got %0d want 4", count); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b1 || out_tag !== 4'd0 || out_result !== 16'd10)
      $display("FAIL bp_hold got valid=%b tag=%h result=%h want 1/0/000a", out_valid, out_tag, out_result); else n_pass++;
    // Pop and push requested together while full: the push must be refused.
    set_op(16'h7777, 16'h0, 3'b000, 4'hF);
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_no_bypass got %b want 0", in_ready); else n_pass++;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_chk++; if (out_valid !== 1'b1 || out_tag !== TAG_W'(k) || out_result !== WIDTH'(k + 10))
        $display("FAIL bp_order_%0d got valid=%b tag=%h result=%h want 1/%h/%h", k, out_valid, out_tag, out_result, TAG_W'(k), WIDTH'(k + 10)); else n_pass++;
    end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL bp_empty got valid=%b count=%0d want 0/0", out_valid, count); else n_pass++;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(WIDTH'(i + 1), 16'h1, 3'b000, TAG_W'(i + 8));
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    n_chk++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL rstmid got count=%0d valid=%b want 0/0", count, out_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rstmid_stale_%0d got %b want 0", i, out_valid); else n_pass++;
    end
  endtask

  task automatic test_random;
    txn_t q[$];
    txn_t slot;
    logic slot_valid = 1'b0;
    logic do_push, do_pop;
    int   errs = 0;
    slot = '{res: '0, tag: '0, err: 1'b0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      in_op     = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (in_ready !== (q.size() < DEPTH) || count !== 3'(q.size()) || out_valid !== slot_valid || alu_op === 3'b111) begin
        errs++;
        if (errs <= 5)
          $display("FAIL rand_ctrl cyc=%0d got ready=%b count=%0d valid=%b alu_op=%b want %b/%0d/%b/not111",
                   cyc, in_ready, count, out_valid, alu_op, q.size() < DEPTH, q.size(), slot_valid);
      end
      if (slot_valid && (out_result !== slot.res || out_tag !== slot.tag || out_err !== slot.err)) begin
        errs++;
        if (errs <= 5)
          $display("FAIL rand_data cyc=%0d got %h/%h/%b want %h/%h/%b",
                   cyc, out_result, out_tag, out_err, slot.res, slot.tag, slot.err);
      end
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && (!slot_valid || out_ready);
      if (do_pop) begin
        slot = q.pop_front();
        slot_valid = 1'b1;
      end else if (slot_valid && out_ready) begin
        slot_valid = 1'b0;
      end
      if (do_push) q.push_back(expect_op(in_a, in_b, in_op, in_tag));
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++; if (errs != 0) $display("FAIL rand_run got %0d errors want 0", errs); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_wrap();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
